instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Fetch stage sitting in front of a combinational instruction ROM. Owns the
//   program counter, presents it as the ROM word address, and registers the
//   returned 32-bit LEGv8 word toward decode over a valid/ready handshake.
//   Unconditional B is resolved here. Redirects (taken CBZ, BR) come from
//   execute. Fetch stops on the halt word (BR XZR).
//
// Ports:
//   clock            in   1   system clock, rising edge
//   reset_n          in   1   synchronous, active-low reset
//   rom_address      out  16  word address to ROM (= pc, combinational)
//   rom_data         in   32  ROM word for rom_address, same cycle
//   instr            out  32  registered instruction to decode
//   instr_pc         out  16  word address instr came from
//   instr_valid      out  1   instr/instr_pc hold a live instruction
//   instr_ready      in   1   decode accepts instr this cycle
//   redirect_valid   in   1   execute requests a pc change
//   redirect_target  in   16  new word address
//   halted           out  1   fetch stopped on HALT_WORD
//   issue_count      out  16  completed handshakes, wraps modulo 2^16
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] HALT_WORD = 32'hD60003E0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic        halted,
    output logic [15:0] issue_count
);

    localparam logic [5:0] B_OPCODE = 6'b000101;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic [15:0] issue_count_q, issue_count_d;

    logic        slot_free;
    logic        handshake;
    logic        is_branch;
    logic [15:0] fetch_next_pc;

    assign slot_free = !instr_valid_q || instr_ready;
    assign handshake = instr_valid_q && instr_ready;
    assign is_branch = (rom_data[31:26] == B_OPCODE);

    // The sign-extended imm26 truncated to 16 bits is just its low 16 bits,
    // so the branch target is a plain modulo-2^16 add.
    assign fetch_next_pc = is_branch ? (pc_q + rom_data[15:0]) : (pc_q + 16'd1);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        issue_count_d = issue_count_q;

        // The handshake completes on its own regardless of what else
        // happens to the slot this cycle (redirect flush, halt detect).
        if (handshake) begin
            issue_count_d = issue_count_q + 16'd1;
        end

        if (redirect_valid) begin
            // Flush wins even over a stalled live instruction.
            pc_d          = redirect_target;
            instr_valid_d = 1'b0;
            state_d       = FETCH;
            halted_d      = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (slot_free) begin
                        if (rom_data == HALT_WORD) begin
                            // Halt word is never issued; pc stays on it.
                            instr_valid_d = 1'b0;
                            state_d       = HALT;
                            halted_d      = 1'b1;
                        end else begin
                            instr_d       = rom_data;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = fetch_next_pc;
                        end
                    end
                end
                HALT: begin
                    if (handshake) begin
                        instr_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 16'h0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            issue_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign rom_address = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A small ROM function supplies the
// program; each step drives inputs on the falling edge, lets one rising edge
// pass, and compares outputs on the next falling edge against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] HALT_W = 32'hD60003E0;

    logic        clock;
    logic        reset_n;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halted;
    logic [15:0] issue_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    instr_fetch_unit #(
        .RESET_PC  (16'h0000),
        .HALT_WORD (HALT_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rom_address     (rom_address),
        .rom_data        (rom_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .issue_count     (issue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program: 0 = first copy-loop word, 1..8 and 11 plain words,
    // 9 = B -7, 10 and 12 = halt, FFFF = plain word (pc wrap test).
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0000: rom_word = 32'h910193E4;
            16'h0001, 16'h0002, 16'h0003, 16'h0004,
            16'h0005, 16'h0006, 16'h0007, 16'h0008,
            16'h000B: rom_word = 32'hAA000000 | {16'h0, a};
            16'h0009: rom_word = 32'h17FFFFF9;
            16'hFFFF: rom_word = 32'hAA00FFFF;
            default:  rom_word = HALT_W;
        endcase
    endfunction

    assign rom_data = rom_word(rom_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic v, input logic [15:0] ipc,
                       input logic [15:0] addr, input logic [15:0] cnt, input logic h);
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        if (v) check({tag, ".instr_pc"}, 32'(instr_pc), 32'(ipc));
        check({tag, ".rom_address"}, 32'(rom_address), 32'(addr));
        check({tag, ".issue_count"}, 32'(issue_count), 32'(cnt));
        check({tag, ".halted"}, 32'(halted), 32'(h));
        $display("step %-10s valid=%0d instr_pc=%04h instr=%08h addr=%04h cnt=%0d halted=%0d",
                 tag, instr_valid, instr_pc, instr, rom_address, issue_count, halted);
    endtask

    initial begin
        reset_n         = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0;
        @(negedge clock);
        tick();
        check("rst.instr", instr, 32'h0);
        check("rst.instr_pc", 32'(instr_pc), 32'h0);
        chk("reset", 1'b0, 16'h0, 16'h0000, 16'd0, 1'b0);

        // Sequential stream 0..9; B at 9 jumps back to 2 (no fetch of 10).
        reset_n = 1'b1;
        tick();
        check("first.instr", instr, 32'h910193E4);
        chk("first", 1'b1, 16'h0, 16'h0001, 16'd0, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk($sformatf("seq%0d", k - 1), 1'b1, 16'(k - 1), 16'(k), 16'(k - 1), 1'b0);
        end
        tick();
        check("b.instr", instr, 32'h17FFFFF9);
        chk("b_issue", 1'b1, 16'h9, 16'h0002, 16'd9, 1'b0);
        tick();
        chk("b_target", 1'b1, 16'h2, 16'h0003, 16'd10, 1'b0);
        tick();
        chk("pc3", 1'b1, 16'h3, 16'h0004, 16'd11, 1'b0);
        tick();
        chk("pc4", 1'b1, 16'h4, 16'h0005, 16'd12, 1'b0);

        // Stall three cycles at instr_pc 4.
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall.instr", instr, 32'hAA000004);
            chk("stall", 1'b1, 16'h4, 16'h0005, 16'd12, 1'b0);
        end
        instr_ready = 1'b1;
        tick();
        chk("unstall", 1'b1, 16'h5, 16'h0006, 16'd13, 1'b0);
        tick();
        chk("pc6", 1'b1, 16'h6, 16'h0007, 16'd14, 1'b0);
        tick();
        chk("pc7", 1'b1, 16'h7, 16'h0008, 16'd15, 1'b0);

        // Stall at 7, then redirect to 10 while still stalled (flush).
        instr_ready = 1'b0;
        tick();
        chk("stall7", 1'b1, 16'h7, 16'h0008, 16'd15, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 16'h000A;
        tick();
        chk("redir_a", 1'b0, 16'h0, 16'h000A, 16'd15, 1'b0);

        // Word at 10 is the halt word.
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        tick();
        chk("halt_a", 1'b0, 16'h0, 16'h000A, 16'd15, 1'b1);
        tick();
        chk("halt_hold", 1'b0, 16'h0, 16'h000A, 16'd15, 1'b1);

        // Redirect out of HALT to 11; halt at 12 with a stalled pending instr.
        redirect_valid  = 1'b1;
        redirect_target = 16'h000B;
        tick();
        chk("redir_b", 1'b0, 16'h0, 16'h000B, 16'd15, 1'b0);
        redirect_valid = 1'b0;
        tick();
        chk("pc11", 1'b1, 16'hB, 16'h000C, 16'd15, 1'b0);
        instr_ready = 1'b0;
        tick();
        chk("pend_hold", 1'b1, 16'hB, 16'h000C, 16'd15, 1'b0);
        instr_ready = 1'b1;
        tick();
        chk("halt_c", 1'b0, 16'h0, 16'h000C, 16'd16, 1'b1);

        // Resume at 3.
        redirect_valid  = 1'b1;
        redirect_target = 16'h0003;
        tick();
        chk("redir_3", 1'b0, 16'h0, 16'h0003, 16'd16, 1'b0);
        redirect_valid = 1'b0;
        tick();
        check("resume.instr", instr, 32'hAA000003);
        chk("resume", 1'b1, 16'h3, 16'h0004, 16'd16, 1'b0);

        // Redirect with a live accepted instr still counts the handshake.
        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFF;
        tick();
        chk("redir_ffff", 1'b0, 16'h0, 16'hFFFF, 16'd17, 1'b0);
        redirect_valid = 1'b0;
        tick();
        chk("wrap", 1'b1, 16'hFFFF, 16'h0000, 16'd17, 1'b0);

        // Reset while stalled with a live instruction.
        instr_ready = 1'b0;
        tick();
        chk("pre_rst", 1'b1, 16'hFFFF, 16'h0000, 16'd17, 1'b0);
        reset_n = 1'b0;
        tick();
        check("rst2.instr", instr, 32'h0);
        check("rst2.instr_pc", 32'(instr_pc), 32'h0);
        chk("reset2", 1'b0, 16'h0, 16'h0000, 16'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
